hazard_stall_unit: RTL and testbench

//  Stall/flush control for the 5-stage pipeline; complements operand forwarding.
//  - Detects hazards that forwarding cannot cover: load-use, ID-stage branch-compare dependencies,
//    and the HI/LO result of the multi-cycle mul/div unit.
//  - Freezes PC and IF/ID, injects ID/EX bubbles, and flushes IF/ID on taken branches.
//  - Sits beside the ID stage; its inputs are taken from the ID, EX and MEM pipeline registers.

---
 rtl/hazard_stall_if.sv | 39 +++
 rtl/hazard_stall_unit.sv | 105 ++++++++++
 tb/tb_hazard_stall_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_if.sv
// Pipeline-side bundle for the hazard/stall unit: ID/EX/MEM hazard sources in,
// stall/flush controls and mul/div busy out.
interface hazard_stall_if #(
  parameter int ADDR_LEN = 5
);
  logic [ADDR_LEN-1:0] id_rs_addr;
  logic [ADDR_LEN-1:0] id_rt_addr;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                id_branch;
  logic                id_reads_hilo;
  logic                id_md_op;
  logic                branch_taken;
  logic [ADDR_LEN-1:0] ex_wb_addr;
  logic                ex_reg_write;
  logic                ex_mem_read;
  logic [ADDR_LEN-1:0] mem_wb_addr;
  logic                mem_mem_read;
  logic                md_start;
  logic                pc_write_en;
  logic                ifid_write_en;
  logic                idex_bubble;
  logic                ifid_flush;
  logic                md_busy;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_branch,
           id_reads_hilo, id_md_op, branch_taken, ex_wb_addr, ex_reg_write,
           ex_mem_read, mem_wb_addr, mem_mem_read, md_start,
    input  pc_write_en, ifid_write_en, idex_bubble, ifid_flush, md_busy
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_branch,
           id_reads_hilo, id_md_op, branch_taken, ex_wb_addr, ex_reg_write,
           ex_mem_read, mem_wb_addr, mem_mem_read, md_start,
    output pc_write_en, ifid_write_en, idex_bubble, ifid_flush, md_busy
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use, ID-branch and HI/LO hazards.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_stall_unit #(
  parameter int ADDR_LEN  = 5,
  parameter int MD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  hazard_stall_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);
  localparam int MD_CNT_W = $clog2(MD_CYCLES + 1);

  typedef enum logic { MD_IDLE, MD_RUN } md_state_e;

  md_state_e           md_state_q;
  logic [MD_CNT_W-1:0] md_cnt_q;
  logic                md_busy_q;

  // Register 0 is hardwired, so it can never be the source of a hazard.
  function automatic logic hit(input logic [ADDR_LEN-1:0] dst,
                               input logic [ADDR_LEN-1:0] src,
                               input logic                use_f);
    return use_f && (src != '0) && (src == dst);
  endfunction

  logic ex_hit, mem_hit;
  logic load_use, br_ex, br_mem, md_haz, stall;

  assign ex_hit   = hit(hz.ex_wb_addr, hz.id_rs_addr, hz.id_uses_rs) |
                    hit(hz.ex_wb_addr, hz.id_rt_addr, hz.id_uses_rt);
  assign mem_hit  = hit(hz.mem_wb_addr, hz.id_rs_addr, hz.id_uses_rs) |
                    hit(hz.mem_wb_addr, hz.id_rt_addr, hz.id_uses_rt);
  assign load_use = hz.ex_mem_read & ex_hit;
  assign br_ex    = hz.id_branch & hz.ex_reg_write & ex_hit;
  assign br_mem   = hz.id_branch & hz.mem_mem_read & mem_hit;
  assign md_haz   = md_busy_q & (hz.id_reads_hilo | hz.id_md_op);
  assign stall    = load_use | br_ex | br_mem | md_haz;

  // Flush only when not stalled: branch operands are not final during a stall.
  always_comb begin
    hz.pc_write_en   = 1'b0;
    hz.ifid_write_en = 1'b0;
    hz.idex_bubble   = 1'b1;
    hz.ifid_flush    = 1'b0;
    if (!rst) begin
      hz.pc_write_en   = ~stall;
      hz.ifid_write_en = ~stall;
      hz.idex_bubble   = stall;
      hz.ifid_flush    = ~stall & hz.id_branch & hz.branch_taken;
    end
  end

  assign hz.md_busy = md_busy_q;

  // A new md_start always reloads, so the latest op defines when HI/LO is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
      md_busy_q  <= 1'b0;
    end else begin
      case (md_state_q)
        MD_IDLE: if (hz.md_start) begin
          md_state_q <= MD_RUN;
          md_cnt_q   <= MD_CNT_W'(MD_CYCLES - 1);
          md_busy_q  <= 1'b1;
        end
        MD_RUN: if (hz.md_start) begin
          md_cnt_q   <= MD_CNT_W'(MD_CYCLES - 1);
        end else if (md_cnt_q == '0) begin
          md_state_q <= MD_IDLE;
          md_busy_q  <= 1'b0;
        end else begin
          md_cnt_q   <= md_cnt_q - 1'b1;
        end
        default: begin
          md_state_q <= MD_IDLE;
          md_busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && !(&perf_stall_q))          perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.ifid_flush && !(&perf_flush_q))  perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: inputs driven after negedge, outputs
// checked with immediate assertions before the next rising edge.
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_if #(.ADDR_LEN(5)) hif ();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_stall_unit #(.ADDR_LEN(5), .MD_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_flush_cnt_o (perf_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {pc_write_en, ifid_write_en, idex_bubble, ifid_flush, md_busy}.
  task automatic chk_out(input string tag, input logic pc, input logic ifid,
                         input logic bub, input logic fl, input logic busy);
    chk({tag, ".pc_write_en"},   {31'd0, hif.pc_write_en},   {31'd0, pc});
    chk({tag, ".ifid_write_en"}, {31'd0, hif.ifid_write_en}, {31'd0, ifid});
    chk({tag, ".idex_bubble"},   {31'd0, hif.idex_bubble},   {31'd0, bub});
    chk({tag, ".ifid_flush"},    {31'd0, hif.ifid_flush},    {31'd0, fl});
    chk({tag, ".md_busy"},       {31'd0, hif.md_busy},       {31'd0, busy});
  endtask

  task automatic clr();
    hif.id_rs_addr = '0;    hif.id_rt_addr = '0;
    hif.id_uses_rs = 1'b0;  hif.id_uses_rt = 1'b0;
    hif.id_branch = 1'b0;   hif.id_reads_hilo = 1'b0;
    hif.id_md_op = 1'b0;    hif.branch_taken = 1'b0;
    hif.ex_wb_addr = '0;    hif.ex_reg_write = 1'b0;
    hif.ex_mem_read = 1'b0; hif.mem_wb_addr = '0;
    hif.mem_mem_read = 1'b0; hif.md_start = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    clr();
    // Reset values hold even with a taken branch presented
    hif.id_branch = 1'b1; hif.branch_taken = 1'b1;
    #2;
    chk_out("reset", 0, 0, 1, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("reset.perf_stall", perf_stall_cnt, 32'd0);
    chk("reset.perf_flush", perf_flush_cnt, 32'd0);
`endif
    nxt(); rst = 1'b0; #1;
    chk_out("post_reset_flush", 1, 1, 0, 1, 0);

    // 1. load-use on rs=8, then the load moves to MEM and ID is free
    nxt(); clr();
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_wb_addr = 5'd8;
    hif.id_uses_rs = 1; hif.id_rs_addr = 5'd8; #1;
    chk_out("load_use", 0, 0, 1, 0, 0);
    nxt(); clr();
    hif.mem_mem_read = 1; hif.mem_wb_addr = 5'd8;
    hif.id_uses_rs = 1; hif.id_rs_addr = 5'd8; #1;
    chk_out("load_use_free", 1, 1, 0, 0, 0);

    // 2. load to $0, and unused rt match: no stall
    nxt(); clr();
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_wb_addr = 5'd0;
    hif.id_uses_rs = 1; hif.id_rs_addr = 5'd0; #1;
    chk_out("load_r0", 1, 1, 0, 0, 0);
    nxt(); clr();
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_wb_addr = 5'd8;
    hif.id_uses_rs = 1; hif.id_rs_addr = 5'd3;
    hif.id_uses_rt = 0; hif.id_rt_addr = 5'd8; #1;
    chk_out("load_rt_unused", 1, 1, 0, 0, 0);
    hif.id_uses_rt = 1; #1;
    chk_out("load_rt_used", 0, 0, 1, 0, 0);

    // 3. beq on load result: br_ex, br_mem, then flush once
    nxt(); clr();
    hif.id_branch = 1; hif.branch_taken = 1; hif.id_uses_rs = 1; hif.id_rs_addr = 5'd9;
    hif.ex_mem_read = 1; hif.ex_reg_write = 1; hif.ex_wb_addr = 5'd9; #1;
    chk_out("br_load_ex", 0, 0, 1, 0, 0);
    nxt();
    hif.ex_mem_read = 0; hif.ex_reg_write = 0; hif.ex_wb_addr = 5'd0;
    hif.mem_mem_read = 1; hif.mem_wb_addr = 5'd9; #1;
    chk_out("br_load_mem", 0, 0, 1, 0, 0);
    nxt();
    hif.mem_mem_read = 0; hif.mem_wb_addr = 5'd0; #1;
    chk_out("br_load_taken", 1, 1, 0, 1, 0);
    nxt(); clr(); #1;
    chk_out("br_load_after", 1, 1, 0, 0, 0);

    // 4. beq on ALU result (rt=9): one stall, then flush
    nxt(); clr();
    hif.id_branch = 1; hif.branch_taken = 1; hif.id_uses_rt = 1; hif.id_rt_addr = 5'd9;
    hif.ex_reg_write = 1; hif.ex_wb_addr = 5'd9; #1;
    chk_out("br_alu_ex", 0, 0, 1, 0, 0);
    nxt();
    hif.ex_reg_write = 0; hif.ex_wb_addr = 5'd0; hif.mem_wb_addr = 5'd9; #1;
    chk_out("br_alu_taken", 1, 1, 0, 1, 0);

    // 5. mult then mfhi: exactly 8 stall cycles
    nxt(); clr(); hif.md_start = 1; #1;
    chk_out("md_start", 1, 1, 0, 0, 0);
    nxt(); clr(); hif.id_reads_hilo = 1;
    for (int i = 0; i < 8; i++) begin
      #1; chk_out($sformatf("md_stall%0d", i), 0, 0, 1, 0, 1);
      nxt();
    end
    #1; chk_out("md_done", 1, 1, 0, 0, 0);

    // md_start mid-run reloads: busy for 8 cycles after the second start
    nxt(); clr(); hif.md_start = 1;
    nxt(); hif.md_start = 0;
    nxt(); hif.md_start = 1;
    nxt(); hif.md_start = 0; hif.id_md_op = 1;
    for (int i = 0; i < 8; i++) begin
      #1; chk($sformatf("md_reload_busy%0d", i), {31'd0, hif.md_busy}, 32'd1);
      nxt();
    end
    #1; chk_out("md_reload_done", 1, 1, 0, 0, 0);

    // 6. async reset mid mul/div (counter at 4)
    nxt(); clr(); hif.md_start = 1;
    nxt(); hif.md_start = 0; hif.id_reads_hilo = 1;
    nxt(); nxt(); nxt();
    #1; chk_out("md_mid", 0, 0, 1, 0, 1);
    #1; rst = 1'b1; #1;
    chk_out("md_rst", 0, 0, 1, 0, 0);
`ifdef HAZARD_PERF_EN
    chk("md_rst.perf_stall", perf_stall_cnt, 32'd0);
    chk("md_rst.perf_flush", perf_flush_cnt, 32'd0);
`endif
    nxt(); rst = 1'b0; #1;
    chk_out("md_rst_release", 1, 1, 0, 0, 0);

`ifdef HAZARD_PERF_EN
    // one load-use stall and one flush counted
    nxt(); clr();
    hif.ex_mem_read = 1; hif.ex_wb_addr = 5'd8; hif.id_uses_rs = 1; hif.id_rs_addr = 5'd8;
    nxt(); clr(); hif.id_branch = 1; hif.branch_taken = 1;
    nxt(); clr(); #1;
    chk("perf_stall", perf_stall_cnt, 32'd1);
    chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
